// File: rtl/mult_pkg.sv
// Shared constants and types for the shift-add multiplier controller/datapath pair.
package mult_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned PROD_W    = 2 * DEF_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

  // Step counter must be able to hold WIDTH itself.
  function automatic int unsigned cnt_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mult_step_counter.sv
// Step counter for the shift-add multiplier: cleared on init, advances per accepted step,
// flags the step that completes the multiply.
module mult_step_counter
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = cnt_w(WIDTH)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic term_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_c = en & (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/multiplier_datapath.sv
// Shift-add multiplier datapath: loads operands on init, one conditional add and shift per SR
// while busy, raises done after WIDTH steps and holds the product.
module multiplier_datapath
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = cnt_w(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               init,
  input  logic               SR,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done,
  output logic               lsb
);

  localparam int unsigned P_W = 2 * WIDTH;

  mult_state_e    state_q, state_d;
  logic [P_W-1:0]   a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [P_W-1:0]   p_q, p_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             step_en;
  logic             term_c;

  // init wins over SR, and SR only counts while an operation is in flight.
  assign step_en = SR & busy_q & ~init;

  mult_step_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_step_counter (
    .clk    (clock),
    .reset  (reset),
    .clr    (init),
    .en     (step_en),
    .term_c (term_c)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    if (init) begin
      a_d     = P_W'(multiplicand);
      b_d     = multiplier;
      p_d     = '0;
      state_d = ST_RUN;
    end else if (step_en) begin
      if (b_q[0]) begin
        p_d = p_q + a_q;
      end
      a_d = a_q << 1;
      b_d = b_q >> 1;
      if (term_c) begin
        state_d = ST_DONE;
      end
    end
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign product = p_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign lsb     = b_q[0];

endmodule

// File: tb/tb_multiplier_datapath.sv
// Self-checking bench for multiplier_datapath: directed vectors, corner sequences and random
// strobes checked against an arithmetic reference model.
module tb_multiplier_datapath;

  localparam int unsigned W = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic           init;
  logic           SR;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic [2*W-1:0] product;
  logic           busy;
  logic           done;
  logic           lsb;

  int total = 0;
  int bad   = 0;

  // Reference model: operands, number of steps taken, status.
  int m_a = 0;
  int m_b = 0;
  int m_k = 0;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;

  typedef struct {
    int a;
    int b;
    int exp_p;
  } vec_t;

  vec_t vecs[$];

  multiplier_datapath dut (
    .clock        (clock),
    .reset        (reset),
    .init         (init),
    .SR           (SR),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .done         (done),
    .lsb          (lsb)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int model_prod();
    return m_a * (m_b % (1 << m_k));
  endfunction

  // Drive one cycle, advance the model at the edge, then compare all outputs.
  task automatic cyc(input bit r, input bit i, input bit s, input int a, input int b);
    reset        = r;
    init         = i;
    SR           = s;
    multiplicand = W'(a);
    multiplier   = W'(b);
    @(posedge clock);
    if (r) begin
      m_a = 0; m_b = 0; m_k = 0; m_busy = 0; m_done = 0;
    end else if (i) begin
      m_a = a % 256; m_b = b % 256; m_k = 0; m_busy = 1; m_done = 0;
    end else if (s && m_busy) begin
      m_k++;
      if (m_k == int'(W)) begin
        m_busy = 0;
        m_done = 1;
      end
    end
    #1;
    chk("model_product", 32'(product), 32'(model_prod()));
    chk("model_busy", 32'(busy), 32'(m_busy));
    chk("model_done", 32'(done), 32'(m_done));
    chk("model_lsb", 32'(lsb), 32'((m_b >> m_k) & 1));
  endtask

  task automatic run_steps(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 1, 0, 0);
  endtask

  initial begin
    int busy_cycles;
    int lsb_exp[8];

    reset = 1'b1; init = 1'b0; SR = 1'b0; multiplicand = '0; multiplier = '0;

    // Reset and post-reset idle with stray SR pulses.
    cyc(1, 0, 0, 0, 0);
    chk("reset_product", 32'(product), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_lsb", 32'(lsb), 0);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 1, 0, 0);
      chk("idle_product", 32'(product), 0);
      chk("idle_done", 32'(done), 0);
      chk("idle_busy", 32'(busy), 0);
    end

    // 13 x 11: lsb sequence, busy duration, product.
    lsb_exp = '{1, 1, 0, 1, 0, 0, 0, 0};
    busy_cycles = 0;
    cyc(0, 1, 0, 13, 11);
    for (int k = 0; k < 8; k++) begin
      chk("13x11_lsb", 32'(lsb), 32'(lsb_exp[k]));
      if (busy) busy_cycles++;
      cyc(0, 0, 1, 0, 0);
    end
    chk("13x11_busy_cycles", 32'(busy_cycles), 8);
    chk("13x11_busy_after", 32'(busy), 0);
    chk("13x11_done", 32'(done), 1);
    chk("13x11_product", 32'(product), 143);

    // Table of operand pairs with hand-computed products.
    vecs.push_back('{255, 255, 65025});
    vecs.push_back('{0, 200, 0});
    vecs.push_back('{200, 0, 0});
    vecs.push_back('{1, 255, 255});
    vecs.push_back('{128, 2, 256});
    vecs.push_back('{128, 128, 16384});
    vecs.push_back('{17, 15, 255});
    foreach (vecs[v]) begin
      cyc(0, 1, 0, vecs[v].a, vecs[v].b);
      run_steps(7);
      chk("vec_done_early", 32'(done), 0);
      run_steps(1);
      chk("vec_done", 32'(done), 1);
      chk("vec_product", 32'(product), 32'(vecs[v].exp_p));
    end

    // 7 x 9 with gapped strobes, then extra SR after done.
    cyc(0, 1, 0, 7, 9);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0);
    end
    chk("gap_product", 32'(product), 63);
    chk("gap_done", 32'(done), 1);
    run_steps(3);
    chk("extra_product", 32'(product), 63);
    chk("extra_done", 32'(done), 1);
    chk("extra_busy", 32'(busy), 0);

    // Restart: init with SR in the same cycle aborts 5 x 6 and starts 3 x 4.
    cyc(0, 1, 0, 5, 6);
    run_steps(4);
    cyc(0, 1, 1, 3, 4);
    chk("restart_product_cleared", 32'(product), 0);
    chk("restart_busy", 32'(busy), 1);
    run_steps(7);
    chk("restart_not_done", 32'(done), 0);
    run_steps(1);
    chk("restart_done", 32'(done), 1);
    chk("restart_product", 32'(product), 12);

    // Reset mid-operation, then SR without init does nothing.
    cyc(0, 1, 0, 100, 100);
    run_steps(3);
    cyc(1, 0, 0, 0, 0);
    chk("midreset_product", 32'(product), 0);
    chk("midreset_busy", 32'(busy), 0);
    chk("midreset_done", 32'(done), 0);
    run_steps(3);
    chk("postreset_product", 32'(product), 0);
    chk("postreset_done", 32'(done), 0);

    // Random strobes and operands against the model.
    for (int k = 0; k < 600; k++) begin
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 60,
          int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
